// File: rtl/sudoku_play_ctrl.sv
// sudoku_play_ctrl
// Sequences puzzle loading into the Sudoku solver and arbitrates the solver's
// single cell-write port between the handwriting recognizer (rec_*) and the
// keypad (key_*). After each write it samples the solver's valid flag and
// reports a solved board.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   new_game                    (re)load puzzle request, overrides everything
//   rec_req/row/col/data, rec_ack   recognizer move handshake
//   key_req/row/col/data, key_ack   keypad move handshake
//   reject                      pulses with an ack when the move is refused
//   slv_start, slv_read         solver load strobe / cell write strobe
//   slv_row/col/data            latched cell address and value for the solver
//   slv_blank, slv_valid        editable-cell mask and solved flag from solver
//   state, solved, move_count   status: FSM state, solved flag, accepted writes
module sudoku_play_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             new_game,
    input  logic             rec_req,
    input  logic [3:0]       rec_row,
    input  logic [3:0]       rec_col,
    input  logic [3:0]       rec_data,
    output logic             rec_ack,
    input  logic             key_req,
    input  logic [3:0]       key_row,
    input  logic [3:0]       key_col,
    input  logic [3:0]       key_data,
    output logic             key_ack,
    output logic             reject,
    output logic             slv_start,
    output logic             slv_read,
    output logic [3:0]       slv_row,
    output logic [3:0]       slv_col,
    output logic [3:0]       slv_data,
    input  logic [80:0]      slv_blank,
    input  logic             slv_valid,
    output logic [2:0]       state,
    output logic             solved,
    output logic [CNT_W-1:0] move_count
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_PLAY   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_CHECK  = 3'd5,
        ST_SOLVED = 3'd6
    } state_t;

    state_t           state_q, state_d;
    logic             prio_key_q, prio_key_d;   // 1: keypad wins a tie
    logic [3:0]       row_q, row_d, col_q, col_d, data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       gnt_rec_s, gnt_key_s;
    logic [3:0] mv_row_s, mv_col_s, mv_data_s;
    logic [6:0] idx_s;
    logic       legal_s;

    // Round-robin grant and legality check of the granted move
    always_comb begin
        gnt_rec_s = 1'b0;
        gnt_key_s = 1'b0;
        // Grants only happen where a move can be consumed, never while loading
        if (((state_q == ST_PLAY) || (state_q == ST_SOLVED)) && !new_game) begin
            if (rec_req && (!key_req || !prio_key_q)) begin
                gnt_rec_s = 1'b1;
            end else if (key_req) begin
                gnt_key_s = 1'b1;
            end else begin
                gnt_rec_s = 1'b0;
            end
        end else begin
            gnt_rec_s = 1'b0;
        end
        mv_row_s  = gnt_key_s ? key_row  : rec_row;
        mv_col_s  = gnt_key_s ? key_col  : rec_col;
        mv_data_s = gnt_key_s ? key_data : rec_data;
        // Index only meaningful when row/col are in range; the range terms guard it
        idx_s     = ({3'd0, mv_row_s} * 7'd9) + {3'd0, mv_col_s};
        legal_s   = (mv_row_s <= 4'd8) && (mv_col_s <= 4'd8) &&
                    (mv_data_s <= 4'd9) && slv_blank[idx_s];
    end

    // Next-state, datapath updates and strobe outputs
    always_comb begin
        state_d    = state_q;
        prio_key_d = prio_key_q;
        row_d      = row_q;
        col_d      = col_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        rec_ack    = gnt_rec_s;
        key_ack    = gnt_key_s;
        reject     = 1'b0;
        slv_start  = 1'b0;
        slv_read   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_LOAD: begin
                slv_start = 1'b1;
                state_d   = ST_SETTLE;
            end
            ST_SETTLE: begin
                state_d = slv_valid ? ST_SOLVED : ST_PLAY;
            end
            ST_PLAY: begin
                if (gnt_rec_s || gnt_key_s) begin
                    prio_key_d = gnt_rec_s;
                    if (legal_s) begin
                        row_d   = mv_row_s;
                        col_d   = mv_col_s;
                        data_d  = mv_data_s;
                        state_d = ST_WRITE;
                    end else begin
                        reject = 1'b1;
                    end
                end else begin
                    state_d = ST_PLAY;
                end
            end
            ST_WRITE: begin
                slv_read = 1'b1;
                cnt_d    = (cnt_q == {CNT_W{1'b1}}) ? cnt_q
                                                    : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                state_d  = ST_CHECK;
            end
            ST_CHECK: begin
                state_d = slv_valid ? ST_SOLVED : ST_PLAY;
            end
            ST_SOLVED: begin
                // Board frozen: every granted move is consumed and refused
                if (gnt_rec_s || gnt_key_s) begin
                    prio_key_d = gnt_rec_s;
                    reject     = 1'b1;
                end else begin
                    reject = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (new_game) begin
            state_d = ST_LOAD;
            cnt_d   = {CNT_W{1'b0}};
        end else begin
            cnt_d = cnt_d;
        end
    end

    // State, priority pointer, latched move and counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            prio_key_q <= 1'b0;
            row_q      <= 4'd0;
            col_q      <= 4'd0;
            data_q     <= 4'd0;
            cnt_q      <= {CNT_W{1'b0}};
        end else begin
            state_q    <= state_d;
            prio_key_q <= prio_key_d;
            row_q      <= row_d;
            col_q      <= col_d;
            data_q     <= data_d;
            cnt_q      <= cnt_d;
        end
    end

    assign state      = state_q;
    assign solved     = (state_q == ST_SOLVED);
    assign move_count = cnt_q;
    assign slv_row    = row_q;
    assign slv_col    = col_q;
    assign slv_data   = data_q;

endmodule
